// File: rtl/priority_encoder_seq_if.sv
// ---------------------------------------------------------------------------
// priority_encoder_seq_if
// Bundles the request-side and beat-side handshakes of priority_encoder_seq.
//   in_valid/in_ready/in_req   : 8-bit request vector, valid/ready handshake
//   out_valid/out_ready        : one beat per set bit, valid/ready handshake
//   out_idx/out_last           : index being emitted, final-beat flag
//   empty_pulse                : one-cycle flag for an accepted all-zero vector
// master: the environment (drives requests, consumes beats)
// slave : the encoder itself
// ---------------------------------------------------------------------------
interface priority_encoder_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_req;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       empty_pulse;

  modport master (
    output in_valid, in_req, out_ready,
    input  in_ready, out_valid, out_idx, out_last, empty_pulse
  );

  modport slave (
    input  in_valid, in_req, out_ready,
    output in_ready, out_valid, out_idx, out_last, empty_pulse
  );
endinterface

// File: rtl/priority_encoder_seq.sv
// ---------------------------------------------------------------------------
// priority_encoder_seq
// Captures an 8-bit request vector and emits the index of every set bit as a
// sequence of valid/ready beats, lowest index first (MSB_FIRST=0) or highest
// index first (MSB_FIRST=1). An all-zero vector produces no beats, only a
// one-cycle empty_pulse.
// Ports:
//   clk     : clock, all state updates on the rising edge
//   rst     : asynchronous active-high reset
//   bus_if  : priority_encoder_seq_if.slave (request and beat handshakes)
// ---------------------------------------------------------------------------
module priority_encoder_seq #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  priority_encoder_seq_if.slave bus_if
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic       empty_q, empty_d;

  logic [2:0] sel_idx;
  logic       sel_last;

  // Index selection: later assignments win, so scanning from the far end
  // toward the preferred end leaves the preferred set bit in sel_idx.
  always_comb begin
    sel_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (MSB_FIRST) begin
        if (pend_q[i]) sel_idx = 3'(i);
      end else begin
        if (pend_q[7-i]) sel_idx = 3'(7 - i);
      end
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign sel_last = (pend_q != 8'd0) && ((pend_q & (pend_q - 8'd1)) == 8'd0);

  // Next-state and output logic.
  always_comb begin
    state_d          = state_q;
    pend_d           = pend_q;
    empty_d          = 1'b0;
    bus_if.in_ready  = 1'b0;
    bus_if.out_valid = 1'b0;
    bus_if.out_idx   = 3'd0;
    bus_if.out_last  = 1'b0;

    case (state_q)
      IDLE: begin
        bus_if.in_ready = 1'b1;
        if (bus_if.in_valid) begin
          if (bus_if.in_req != 8'd0) begin
            pend_d  = bus_if.in_req;
            state_d = EMIT;
          end else begin
            empty_d = 1'b1;
          end
        end
      end
      EMIT: begin
        bus_if.out_valid = 1'b1;
        bus_if.out_idx   = sel_idx;
        bus_if.out_last  = sel_last;
        if (bus_if.out_ready) begin
          pend_d = pend_q & ~(8'd1 << sel_idx);
          if (sel_last) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= 8'd0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      empty_q <= empty_d;
    end
  end

  assign bus_if.empty_pulse = empty_q;

endmodule

// File: tb/tb_priority_encoder_seq.sv
module tb_priority_encoder_seq;

  typedef struct packed {
    logic       empty;
    logic [2:0] idx;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid_r = 1'b0;
  logic [7:0] in_req_r = 8'd0;
  logic       ready_r = 1'b0;
  int         ready_mode = 0;   // 0: always ready, 1: random, 2: stalled

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  priority_encoder_seq_if if0 ();
  priority_encoder_seq_if if1 ();

  assign if0.in_valid  = in_valid_r;
  assign if0.in_req    = in_req_r;
  assign if0.out_ready = ready_r;
  assign if1.in_valid  = in_valid_r;
  assign if1.in_req    = in_req_r;
  assign if1.out_ready = ready_r;

  priority_encoder_seq #(.MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus_if(if0));
  priority_encoder_seq #(.MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst(rst), .bus_if(if1));

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: the set bits of the vector in the requested order,
  // with the final beat flagged; a zero vector yields a single empty marker.
  task automatic push_expected(input logic [7:0] v);
    int idxs[$];
    exp_t e;
    if (v == 8'd0) begin
      e = '{empty: 1'b1, idx: 3'd0, last: 1'b0};
      q0.push_back(e);
      q1.push_back(e);
    end else begin
      for (int i = 0; i < 8; i++) if (v[i]) idxs.push_back(i);
      for (int j = 0; j < idxs.size(); j++) begin
        q0.push_back('{empty: 1'b0, idx: 3'(idxs[j]), last: (j == idxs.size() - 1)});
        q1.push_back('{empty: 1'b0, idx: 3'(idxs[idxs.size() - 1 - j]), last: (j == idxs.size() - 1)});
      end
    end
  endtask

  // Downstream ready generator.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       ready_r = 1'b1;
      1:       ready_r = 1'($urandom_range(0, 1));
      default: ready_r = 1'b0;
    endcase
  end

  // Monitor / scoreboard.
  bit       prev_stall[2];
  bit       prev_xfer[2];
  bit       prev_last[2];
  bit [2:0] prev_idx[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      prev_stall[k] = 0; prev_xfer[k] = 0; prev_last[k] = 0; prev_idx[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        logic       ov, ir, ol, ep, orr;
        logic [2:0] oi;
        exp_t       e;
        bit         have;
        string      tag;
        tag = (k == 0) ? "lsb" : "msb";
        ov  = (k == 0) ? if0.out_valid   : if1.out_valid;
        ir  = (k == 0) ? if0.in_ready    : if1.in_ready;
        ol  = (k == 0) ? if0.out_last    : if1.out_last;
        ep  = (k == 0) ? if0.empty_pulse : if1.empty_pulse;
        oi  = (k == 0) ? if0.out_idx     : if1.out_idx;
        orr = ready_r;
        if (rst) begin
          prev_stall[k] = 0; prev_xfer[k] = 0;
          continue;
        end
        check(ir == !ov, {tag, "_in_ready_vs_out_valid"}, int'(ir), int'(!ov));
        if (!ov) check(oi == 3'd0 && ol == 1'b0, {tag, "_idle_idx_last"}, int'({oi, ol}), 0);
        if (prev_stall[k])
          check(ov && oi == prev_idx[k] && ol == prev_last[k], {tag, "_stall_hold"},
                int'({ov, oi, ol}), int'({1'b1, prev_idx[k], prev_last[k]}));
        if (prev_xfer[k])
          check(ov == !prev_last[k], {tag, "_beat_continuity"}, int'(ov), int'(!prev_last[k]));
        if (ep) begin
          check(!ov, {tag, "_empty_no_beat"}, int'(ov), 0);
          have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
          if (have) begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            check(e.empty == 1'b1, {tag, "_empty_pulse_expected"}, 1, int'(e.empty));
          end else begin
            check(1'b0, {tag, "_unexpected_empty_pulse"}, 1, 0);
          end
        end
        if (ov && orr) begin
          have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
          if (have) begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            check(!e.empty && oi == e.idx && ol == e.last, {tag, "_beat_idx_last"},
                  int'({oi, ol}), int'({e.idx, e.last}));
            $display("beat %s: idx=%0d last=%0d", tag, oi, ol);
          end else begin
            check(1'b0, {tag, "_unexpected_beat"}, int'(oi), -1);
          end
        end
        prev_stall[k] = ov && !orr;
        prev_xfer[k]  = ov && orr;
        prev_last[k]  = ol;
        prev_idx[k]   = oi;
      end
    end
  end

  // Present one vector; inputs are noise while the blocks are busy.
  task automatic send(input logic [7:0] v);
    int  n;
    bool_ok: begin end
    n = 0;
    @(negedge clk);
    while (!(if0.in_ready && if1.in_ready) && n < 300) begin
      in_valid_r = 1'($urandom_range(0, 1));
      in_req_r   = 8'($urandom);
      n++;
      @(negedge clk);
    end
    if (n >= 300) begin
      check(1'b0, "wait_in_ready_timeout", 0, 1);
      in_valid_r = 1'b0;
      return;
    end
    in_valid_r = 1'b1;
    in_req_r   = v;
    push_expected(v);
    @(posedge clk);
    #1;
    in_valid_r = 1'b0;
    in_req_r   = 8'($urandom);
    @(negedge clk);
    check(if0.out_valid == (v != 8'd0) && if1.out_valid == (v != 8'd0), "accept_latency",
          int'({if0.out_valid, if1.out_valid}), (v != 8'd0) ? 3 : 0);
    check(if0.empty_pulse == (v == 8'd0) && if1.empty_pulse == (v == 8'd0), "empty_pulse_latency",
          int'({if0.empty_pulse, if1.empty_pulse}), (v == 8'd0) ? 3 : 0);
    $display("sent vector 0x%02h (ready_mode=%0d)", v, ready_mode);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!((q0.size() == 0) && (q1.size() == 0) && if0.in_ready && if1.in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(n < 500, "drain_timeout", n, 0);
  endtask

  initial begin
    logic [7:0] v;
    // Reset state
    #2;
    check(if0.in_ready && if1.in_ready, "reset_in_ready", int'({if0.in_ready, if1.in_ready}), 3);
    check(!if0.out_valid && !if1.out_valid, "reset_out_valid", int'({if0.out_valid, if1.out_valid}), 0);
    check(!if0.empty_pulse && if0.out_idx == 3'd0 && !if0.out_last, "reset_outputs",
          int'({if0.empty_pulse, if0.out_idx, if0.out_last}), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Directed vectors
    ready_mode = 0; send(8'b1010_0100); drain();
    ready_mode = 2; send(8'h81);
    repeat (2) begin
      @(negedge clk);
      check(if0.out_valid && if0.out_idx == 3'd0, "stall_idx0_hold", int'(if0.out_idx), 0);
    end
    ready_mode = 0; drain();
    send(8'h00); drain();
    check(if0.in_ready && !if0.out_valid, "empty_stays_idle", int'({if0.in_ready, if0.out_valid}), 2);
    send(8'hFF); drain();
    ready_mode = 1; send(8'hFF); drain();
    ready_mode = 0; send(8'h01); send(8'h80); drain();

    // Random vectors, random back-pressure
    for (int t = 0; t < 40; t++) begin
      ready_mode = $urandom_range(0, 1);
      v = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      send(v);
    end
    ready_mode = 0;
    drain();

    // Asynchronous reset after two beats of 0xFF
    send(8'hFF);
    @(posedge clk); @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    q0.delete(); q1.delete();
    #1;
    check(!if0.out_valid && !if1.out_valid, "async_reset_out_valid", int'({if0.out_valid, if1.out_valid}), 0);
    check(if0.in_ready && if1.in_ready, "async_reset_in_ready", int'({if0.in_ready, if1.in_ready}), 3);
    in_valid_r = 1'b1; in_req_r = 8'h3C;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    in_valid_r = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check(!if0.out_valid && !if1.out_valid && !if0.empty_pulse, "post_reset_quiet",
            int'({if0.out_valid, if1.out_valid, if0.empty_pulse}), 0);
    end
    send(8'h24); drain();

    check(q0.size() == 0 && q1.size() == 0, "scoreboard_empty", q0.size() + q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0t, expected finish earlier", $time);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
